// File: rtl/lpf_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its neighbours: the pixel source,
// the 3x3 low-pass filter datapath and the output sink. The sequencer takes the master view.
interface lpf_frame_sequencer_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       filt_rst;
    logic       filt_enable;
    logic       filt_enable_process;
    logic [7:0] filt_data;
    logic [7:0] filt_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    modport master (
        input  start, in_valid, in_data, filt_result, out_ready,
        output in_ready, filt_rst, filt_enable, filt_enable_process, filt_data,
               out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, in_valid, in_data, filt_result, out_ready,
        input  in_ready, filt_rst, filt_enable, filt_enable_process, filt_data,
               out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/lpf_frame_sequencer.sv
// Frame controller for the 3x3 low-pass filter: clears the filter, loads one frame,
// then steps the filter once per output pixel under valid/ready backpressure.
module lpf_frame_sequencer #(
    parameter int DEPTH  = 410,
    parameter int WIDTH  = 361,
    parameter int PIXELS = DEPTH * WIDTH,
    parameter int CNT_W  = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    lpf_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        PROCESS,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]   proc_cnt_q, proc_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               load_fire;
    logic               proc_fire;

    // A new process strobe is allowed only when the output slot is empty or being drained.
    assign load_fire = (state_q == LOAD) && bus.in_valid;
    assign proc_fire = (state_q == PROCESS) && (!out_valid_q || bus.out_ready);

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        proc_cnt_d  = proc_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                load_cnt_d  = '0;
                proc_cnt_d  = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = LOAD;
            end
            LOAD: begin
                if (load_fire) begin
                    if (load_cnt_q == LAST_IDX) begin
                        state_d = PROCESS;
                    end else begin
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                    end
                end
            end
            PROCESS: begin
                if (proc_fire) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (proc_cnt_q == LAST_IDX);
                    if (proc_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        proc_cnt_d = proc_cnt_q + CNT_W'(1);
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            proc_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            proc_cnt_q  <= proc_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // The filter is held in reset for the whole time the sequencer itself is in reset.
    assign bus.filt_rst            = !rst || (state_q == CLEAR);
    assign bus.in_ready            = (state_q == LOAD);
    assign bus.filt_enable         = load_fire;
    assign bus.filt_enable_process = proc_fire;
    assign bus.filt_data           = bus.in_data;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_data            = bus.filt_result;
    assign bus.out_last            = out_last_q;
    assign bus.busy                = (state_q != IDLE);
    assign bus.done                = (state_q == DONE);

endmodule

// File: tb/tb_lpf_frame_sequencer.sv
// Scoreboard bench for lpf_frame_sequencer on a 4x3 frame with a behavioural
// zero-padded 3x3 averaging filter standing in for the real datapath.
module tb_lpf_frame_sequencer;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 3;
    localparam int PIXELS = DEPTH * WIDTH;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lpf_frame_sequencer_if bus ();

    lpf_frame_sequencer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PIXELS(PIXELS),
        .CNT_W (18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Hand-computed outputs for a constant image of 90: corners 4/9, edges 6/9, interior 9/9.
    logic [7:0] exp_img [PIXELS] = '{8'd40, 8'd60, 8'd60, 8'd40, 8'd60, 8'd90,
                                     8'd90, 8'd60, 8'd40, 8'd60, 8'd60, 8'd40};

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_load = 0;
    int n_proc = 0;
    int n_acc = 0;
    int n_done = 0;
    int frame_loads = 0;
    int first_proc = -1;
    int last_proc = -1;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'd0;
    logic       expect_done = 1'b0;

    logic [7:0] fmem [PIXELS];
    int f_load = 0;
    int f_proc = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int lpf_at(input int idx);
        int row;
        int col;
        int sum;
        row = idx % DEPTH;
        col = idx / DEPTH;
        sum = 0;
        for (int dc = -1; dc <= 1; dc++) begin
            for (int dr = -1; dr <= 1; dr++) begin
                if ((row + dr) >= 0 && (row + dr) < DEPTH && (col + dc) >= 0 && (col + dc) < WIDTH) begin
                    sum += int'(fmem[(col + dc) * DEPTH + row + dr]);
                end
            end
        end
        return sum / 9;
    endfunction

    always @(posedge clk) begin
        if (bus.filt_rst) begin
            for (int i = 0; i < PIXELS; i++) fmem[i] <= 8'd0;
            f_load <= 0;
            f_proc <= 0;
            bus.filt_result <= 8'd0;
        end else if (bus.filt_enable) begin
            if (f_load < PIXELS) fmem[f_load] <= bus.filt_data;
            f_load <= f_load + 1;
        end else if (bus.filt_enable_process) begin
            if (f_proc < PIXELS) bus.filt_result <= 8'(lpf_at(f_proc));
            f_proc <= f_proc + 1;
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard on every accepted output.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst === 1'b1) begin
            if (bus.filt_rst) frame_loads = 0;
            if (bus.filt_enable || bus.filt_enable_process)
                check_output("strobe_exclusive", 32'(bus.filt_enable & bus.filt_enable_process), 0);
            if (bus.filt_enable) begin
                check_output("load_needs_ready", 32'(bus.in_ready), 1);
                n_load++;
                frame_loads++;
            end
            if (bus.filt_enable_process) begin
                check_output("proc_after_all_loads", frame_loads, PIXELS);
                if (first_proc < 0) first_proc = cyc;
                last_proc = cyc;
                n_proc++;
            end
            if (stall_prev && bus.out_valid)
                check_output("stall_data_hold", 32'(bus.out_data), 32'(stall_data));
            if (bus.out_valid && !bus.out_ready)
                check_output("stall_no_proc", 32'(bus.filt_enable_process), 0);
            if (expect_done) begin
                check_output("done_after_last", 32'(bus.done), 1);
                expect_done = 1'b0;
            end
            if (bus.done) n_done++;
            if (bus.out_valid && bus.out_ready) begin
                check_output("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_output("out_data", 32'(bus.out_data), 32'(e.data));
                    check_output("out_last", 32'(bus.out_last), 32'(e.last));
                    if (e.last) expect_done = 1'b1;
                end
                n_acc++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
        end else begin
            stall_prev  = 1'b0;
            expect_done = 1'b0;
        end
    end

    task automatic apply_stimulus(input int gap_mode, input int stall_at, input int abort_at,
                                  input bit check_b2b);
        int  base_load = n_load;
        int  base_proc = n_proc;
        int  base_acc  = n_acc;
        int  base_done = n_done;
        int  k = 0;
        int  stall_left = 0;
        bit  stalled_once = 1'b0;
        bit  spur_load = 1'b0;
        bit  spur_proc = 1'b0;
        bit  finished = 1'b0;
        bit  aborted = 1'b0;
        for (int i = 0; i < PIXELS; i++) sb_q.push_back('{data: exp_img[i], last: (i == PIXELS - 1)});
        first_proc = -1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!finished && k < 400) begin
            bus.in_valid = (gap_mode == 0) ? 1'b1 : (k % 3 == 0);
            bus.in_data  = 8'd90;
            bus.start    = 1'b0;
            if (!spur_load && bus.in_ready && k > 2) begin
                bus.start = 1'b1;
                spur_load = 1'b1;
            end else if (!spur_proc && bus.out_valid && (n_acc - base_acc) == 2) begin
                bus.start = 1'b1;
                spur_proc = 1'b1;
            end
            if (stall_at >= 0 && !stalled_once && bus.out_valid && (n_acc - base_acc) == stall_at) begin
                stall_left   = 3;
                stalled_once = 1'b1;
            end
            bus.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (abort_at >= 0 && (n_acc - base_acc) == abort_at) begin
                bus.start = 1'b0;
                rst = 1'b0;
                #1;
                check_output("abort_out_valid", 32'(bus.out_valid), 0);
                check_output("abort_idle", 32'(bus.busy), 0);
                check_output("abort_filt_rst", 32'(bus.filt_rst), 1);
                sb_q.delete();
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b1;
                aborted  = 1'b1;
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
                if (n_done > base_done) finished = 1'b1;
            end
        end
        check_output("frame_complete", 32'(finished), 1);
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_output("busy_after_frame", 32'(bus.busy), 0);
        if (aborted) begin
            check_output("abort_no_done", n_done - base_done, 0);
        end else begin
            check_output("load_strobes", n_load - base_load, PIXELS);
            check_output("proc_strobes", n_proc - base_proc, PIXELS);
            check_output("outputs_accepted", n_acc - base_acc, PIXELS);
            check_output("done_pulses", n_done - base_done, 1);
            check_output("sb_drained", sb_q.size(), 0);
            if (check_b2b) check_output("proc_back_to_back", last_proc - first_proc, PIXELS - 1);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("reset_filt_rst", 32'(bus.filt_rst), 1);
        check_output("reset_busy", 32'(bus.busy), 0);
        check_output("reset_out_valid", 32'(bus.out_valid), 0);
        check_output("reset_in_ready", 32'(bus.in_ready), 0);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_output("idle_quiet", 32'({bus.busy, bus.in_ready, bus.out_valid, bus.filt_rst,
                                            bus.filt_enable, bus.filt_enable_process}), 0);
        end
        $display("[TB] constant frame");
        apply_stimulus(0, -1, -1, 1'b1);
        $display("[TB] source gaps");
        apply_stimulus(1, -1, -1, 1'b0);
        $display("[TB] sink backpressure");
        apply_stimulus(0, 4, -1, 1'b0);
        $display("[TB] reset mid-process");
        apply_stimulus(0, -1, 6, 1'b0);
        $display("[TB] restart after reset");
        apply_stimulus(0, -1, -1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
